// File: rtl/nes_pad_pkg.sv
// Shared definitions for the NES/SNES pad responder: FSM states, button bit
// order for both pad types, and the default inactivity timeout.
package nes_pad_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // NES shift order: bit i goes out on the i-th slot
  localparam int NES_A      = 0;
  localparam int NES_B      = 1;
  localparam int NES_SELECT = 2;
  localparam int NES_START  = 3;
  localparam int NES_UP     = 4;
  localparam int NES_DOWN   = 5;
  localparam int NES_LEFT   = 6;
  localparam int NES_RIGHT  = 7;

  // SNES shift order; bits 12..15 are reserved and normally sent released
  localparam int SNES_B      = 0;
  localparam int SNES_Y      = 1;
  localparam int SNES_SELECT = 2;
  localparam int SNES_START  = 3;
  localparam int SNES_UP     = 4;
  localparam int SNES_DOWN   = 5;
  localparam int SNES_LEFT   = 6;
  localparam int SNES_RIGHT  = 7;
  localparam int SNES_A      = 8;
  localparam int SNES_X      = 9;
  localparam int SNES_L      = 10;
  localparam int SNES_R      = 11;

  // 1 ms of pin silence at 64 MHz
  localparam int DEFAULT_TIMEOUT = 64000;

endpackage

// File: rtl/pad_pin_sync.sv
// Synchroniser for one asynchronous pad pin, followed by an edge register
// that turns the synchronised level into single-cycle rise/fall pulses.
module pad_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/nes_pad_responder.sv
// Controller-side NES/SNES pad: captures buttons while latch is high and
// shifts them out active-low, one bit per console clock rise.
module nes_pad_responder
  import nes_pad_pkg::*;
#(
  parameter int NUM_BITS       = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [15:0]                   buttons,
  input  logic                          pad_latch,
  input  logic                          pad_clk,
  output logic                          pad_data,
  output logic                          frame_done,
  output logic                          busy,
  output logic [$clog2(NUM_BITS+1)-1:0] bit_index
);

  localparam int IDX_W = $clog2(NUM_BITS + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  state_t              state;
  logic [NUM_BITS-1:0] shreg;
  logic [TO_W-1:0]     to_cnt;
  logic                latch_rise, latch_fall, clk_rise, clk_fall;
  logic                any_edge, in_frame, timed_out;
  logic                unused_buttons;

  assign unused_buttons = ^buttons;

  pad_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (pad_latch),
    .rise  (latch_rise),
    .fall  (latch_fall)
  );

  pad_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (pad_clk),
    .rise  (clk_rise),
    .fall  (clk_fall)
  );

  assign any_edge  = latch_rise | latch_fall | clk_rise | clk_fall;
  assign in_frame  = (state == SHIFT) || (state == DONE);
  // Any pin activity in the same cycle counts as life, so it beats the timeout
  assign timed_out = in_frame && (to_cnt == TO_W'(TIMEOUT_CYCLES)) && !any_edge;

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (any_edge || !in_frame) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_W'(TIMEOUT_CYCLES)) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '1;
      bit_index  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      pad_data   <= 1'b1;
    end else begin
      frame_done <= 1'b0;

      // pad_data follows the state/shift register with one cycle of lag
      case (state)
        IDLE:  pad_data <= 1'b1;
        LOAD:  pad_data <= shreg[0];
        SHIFT: pad_data <= shreg[0];
        DONE:  pad_data <= 1'b0;
      endcase

      if (latch_rise) begin
        state     <= LOAD;
        busy      <= 1'b1;
        shreg     <= ~buttons[NUM_BITS-1:0];
        bit_index <= '0;
      end else if (timed_out) begin
        state     <= IDLE;
        busy      <= 1'b0;
        shreg     <= '1;
        bit_index <= '0;
      end else begin
        case (state)
          IDLE: ;
          LOAD: begin
            shreg     <= ~buttons[NUM_BITS-1:0];
            bit_index <= '0;
            if (latch_fall) state <= SHIFT;
          end
          SHIFT: begin
            if (clk_rise) begin
              shreg     <= {1'b0, shreg[NUM_BITS-1:1]};
              bit_index <= bit_index + IDX_W'(1);
              if (bit_index == IDX_W'(NUM_BITS - 1)) begin
                state      <= DONE;
                busy       <= 1'b0;
                frame_done <= 1'b1;
              end
            end
          end
          DONE: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nes_pad_responder.sv
// Bench for nes_pad_responder: an NES (8-bit) and an SNES (16-bit) instance
// share the pin inputs; frames are driven from a vector table plus corner cases.
module tb_nes_pad_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] buttons;
  logic        pad_latch;
  logic        pad_clk;

  logic        pd8, fd8, busy8;
  logic [3:0]  idx8;
  logic        pd16, fd16, busy16;
  logic [4:0]  idx16;

  int n_cmp = 0;
  int n_err = 0;
  int fd8_cnt = 0;
  int fd16_cnt = 0;

  always #5 clk = ~clk;

  nes_pad_responder #(.NUM_BITS(8)) dut8 (
    .clk        (clk),
    .reset      (reset),
    .buttons    (buttons),
    .pad_latch  (pad_latch),
    .pad_clk    (pad_clk),
    .pad_data   (pd8),
    .frame_done (fd8),
    .busy       (busy8),
    .bit_index  (idx8)
  );

  nes_pad_responder #(.NUM_BITS(16)) dut16 (
    .clk        (clk),
    .reset      (reset),
    .buttons    (buttons),
    .pad_latch  (pad_latch),
    .pad_clk    (pad_clk),
    .pad_data   (pd16),
    .frame_done (fd16),
    .busy       (busy16),
    .bit_index  (idx16)
  );

  always @(negedge clk) begin
    if (fd8)  fd8_cnt++;
    if (fd16) fd16_cnt++;
  end

  typedef struct {
    logic [15:0] btn;
    logic [15:0] exp_data;
    int          nb;
    int          half;
  } frame_vec_t;

  frame_vec_t vecs[$];

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic sel_data(input int nb);
    return (nb == 16) ? pd16 : pd8;
  endfunction

  function automatic logic sel_busy(input int nb);
    return (nb == 16) ? busy16 : busy8;
  endfunction

  function automatic logic [31:0] sel_idx(input int nb);
    return (nb == 16) ? 32'(idx16) : 32'(idx8);
  endfunction

  function automatic int sel_fd(input int nb);
    return (nb == 16) ? fd16_cnt : fd8_cnt;
  endfunction

  // Full frame: latch pulse of 2*half cycles, then nb clock pulses
  task automatic run_frame(input logic [15:0] btn, input logic [15:0] exp_data,
                           input int nb, input int half);
    int fd0;
    buttons   = btn;
    pad_latch = 1'b1;
    cyc(2 * half);
    check("latch_busy", 32'(sel_busy(nb)), 32'd1);
    check("latch_idx", sel_idx(nb), 32'd0);
    pad_latch = 1'b0;
    cyc(half);
    buttons = ~btn;  // must not disturb the frame in flight
    fd0 = sel_fd(nb);
    for (int i = 0; i < nb; i++) begin
      check($sformatf("data_bit%0d", i), 32'(sel_data(nb)), 32'(exp_data[i]));
      check($sformatf("idx_bit%0d", i), sel_idx(nb), 32'(i));
      pad_clk = 1'b1;
      cyc(half);
      pad_clk = 1'b0;
      cyc(half);
    end
    check("frame_done_once", 32'(sel_fd(nb) - fd0), 32'd1);
    check("done_data", 32'(sel_data(nb)), 32'd0);
    check("done_busy", 32'(sel_busy(nb)), 32'd0);
    check("done_idx", sel_idx(nb), 32'(nb));
    pad_clk = 1'b1;
    cyc(half);
    pad_clk = 1'b0;
    cyc(half);
    check("extra_read_data", 32'(sel_data(nb)), 32'd0);
    check("extra_read_no_done", 32'(sel_fd(nb) - fd0), 32'd1);
  endtask

  task automatic clk_pulses(input int n, input int half);
    for (int i = 0; i < n; i++) begin
      pad_clk = 1'b1;
      cyc(half);
      pad_clk = 1'b0;
      cyc(half);
    end
  endtask

  initial begin
    int fd8_0, fd16_0, elapsed;

    reset = 1'b1; buttons = 16'h0000; pad_latch = 1'b0; pad_clk = 1'b0;
    cyc(4);
    check("rst_data8", 32'(pd8), 32'd1);
    check("rst_done8", 32'(fd8), 32'd0);
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_idx8", 32'(idx8), 32'd0);
    check("rst_data16", 32'(pd16), 32'd1);
    check("rst_busy16", 32'(busy16), 32'd0);
    reset = 1'b0;
    cyc(4);

    vecs.push_back('{btn: 16'h0081, exp_data: 16'h007E, nb: 8,  half: 384});
    vecs.push_back('{btn: 16'h0000, exp_data: 16'h00FF, nb: 8,  half: 8});
    vecs.push_back('{btn: 16'h00FF, exp_data: 16'h0000, nb: 8,  half: 8});
    vecs.push_back('{btn: 16'h00A5, exp_data: 16'h005A, nb: 8,  half: 8});
    vecs.push_back('{btn: 16'h1234, exp_data: 16'h00CB, nb: 8,  half: 8});
    vecs.push_back('{btn: 16'h0F01, exp_data: 16'hF0FE, nb: 16, half: 8});
    vecs.push_back('{btn: 16'hFFFF, exp_data: 16'h0000, nb: 16, half: 8});
    vecs.push_back('{btn: 16'h8001, exp_data: 16'h7FFE, nb: 16, half: 8});
    foreach (vecs[k]) run_frame(vecs[k].btn, vecs[k].exp_data, vecs[k].nb, vecs[k].half);

    // Latch held: pad_data tracks ~buttons[0]; clk pulses are ignored
    buttons = 16'h0001; pad_latch = 1'b1;
    cyc(6);
    check("live_b0_pressed", 32'(pd8), 32'd0);
    buttons = 16'h0000;
    cyc(3);
    check("live_b0_released", 32'(pd8), 32'd1);
    buttons = 16'h0001;
    cyc(3);
    check("live_b0_pressed2", 32'(pd8), 32'd0);
    clk_pulses(3, 8);
    check("latch_clk_idx", 32'(idx8), 32'd0);
    check("latch_clk_busy", 32'(busy8), 32'd1);
    pad_latch = 1'b0;
    cyc(8);

    // Re-latch after the 3rd clk rise: abandoned frame never pulses done
    fd8_0 = fd8_cnt;
    buttons = 16'h0081; pad_latch = 1'b1;
    cyc(16);
    pad_latch = 1'b0;
    cyc(8);
    clk_pulses(3, 8);
    check("relatch_pre_idx", 32'(idx8), 32'd3);
    run_frame(16'h0042, 16'h00BD, 8, 8);
    check("relatch_done_count", 32'(fd8_cnt - fd8_0), 32'd1);

    // Latch fall then silence: both instances time out to IDLE
    fd8_0 = fd8_cnt; fd16_0 = fd16_cnt;
    buttons = 16'h0001; pad_latch = 1'b1;
    cyc(16);
    pad_latch = 1'b0;
    elapsed = 0;
    cyc(1000);
    elapsed = 1000;
    check("timeout_still_busy", 32'(busy8), 32'd1);
    while (busy8 && elapsed < 70000) begin
      cyc(1);
      elapsed++;
    end
    check("timeout_bound", 32'(elapsed >= 63990 && elapsed <= 64020), 32'd1);
    cyc(3);
    check("timeout_data8", 32'(pd8), 32'd1);
    check("timeout_busy16", 32'(busy16), 32'd0);
    check("timeout_data16", 32'(pd16), 32'd1);
    check("timeout_idx8", 32'(idx8), 32'd0);
    check("timeout_no_done8", 32'(fd8_cnt - fd8_0), 32'd0);
    check("timeout_no_done16", 32'(fd16_cnt - fd16_0), 32'd0);

    // Reset in SHIFT at bit_index 4, then a clean frame
    buttons = 16'h0000; pad_latch = 1'b1;
    cyc(16);
    pad_latch = 1'b0;
    cyc(8);
    clk_pulses(4, 8);
    check("pre_reset_idx", 32'(idx8), 32'd4);
    check("pre_reset_busy", 32'(busy8), 32'd1);
    reset = 1'b1;
    cyc(1);
    check("mid_reset_data", 32'(pd8), 32'd1);
    check("mid_reset_busy", 32'(busy8), 32'd0);
    check("mid_reset_idx", 32'(idx8), 32'd0);
    reset = 1'b0;
    cyc(4);
    run_frame(16'h0033, 16'h00CC, 8, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nes_pad_responder.md
# nes_pad_responder

Controller-side responder for the NES/SNES serial pad protocol: it accepts console-driven latch and clock pins, captures a parallel button vector on latch, and shifts it out one bit per clock rising edge on an active-low data pin. It sits opposite our console-side receiver. Typical uses are driving a real console or another design's receiver from TinyQV-controlled button state, and loopback verification of the receiver path. Pin inputs are asynchronous and are synchronised internally to clk (64 MHz).

## Interface
Parameters:
- NUM_BITS, 8: bits per frame; 8 = NES, 16 = SNES.
- SYNC_STAGES, 2: flops in each pin synchroniser; minimum 2.
- TIMEOUT_CYCLES, 64000: clk cycles with no pin activity before abandoning a frame (1 ms at 64 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- buttons  in  16  pressed = 1; bit i is sent i-th. Only [NUM_BITS-1:0] are used.
- pad_latch  in  1  async latch pin from the console.
- pad_clk  in  1  async clock pin from the console.
- pad_data  out  1  registered serial data, active-low (0 = pressed).
- frame_done  out  1  one-cycle pulse after the last bit is shifted out.
- busy  out  1  high in LOAD or SHIFT.
- bit_index  out  $clog2(NUM_BITS+1)  index of the bit currently presented.

## Operation
Reset values:
- pad_data = 1, frame_done = 0, busy = 0, bit_index = 0.
- State IDLE; shift register all 1s; timeout counter = 0.

Pin handling:
- Each pin passes through a synchroniser, then an edge detector producing rise/fall pulses.

States:
- IDLE: pad_data = 1. A latch rise moves to LOAD.
- LOAD: every cycle, shreg <= ~buttons[NUM_BITS-1:0] and bit_index <= 0. pad_data tracks shreg[0], i.e. live ~buttons[0] with one cycle of lag. pad_clk edges are ignored. A latch fall moves to SHIFT.
- SHIFT, on a pad_clk rise:
  - shreg shifts right with 0 filled in at the MSB; bit_index increments.
  - If the bit being shifted off is bit NUM_BITS-1, go to DONE and pulse frame_done.
- DONE: pad_data = 0. This matches real pads, where extra reads return "pressed". Further clk rises have no effect.
- Latch rise from SHIFT or DONE: go to LOAD. This restarts a frame mid-transfer.

Boundaries and conflicts:
- Latch rise and clk rise detected in the same cycle: the latch wins.
- Timeout counter: cleared on any latch or clk edge, and counts only in SHIFT/DONE. On reaching TIMEOUT_CYCLES the block goes to IDLE with pad_data = 1; frame_done is not pulsed.
- buttons changes outside LOAD have no effect on the frame in progress.
- Reset asserted mid-frame: all outputs return to their reset values on the next clk edge.

## Timing
- Pin-to-effect latency: an edge sampled at clk cycle 0 changes pad_data at cycle SYNC_STAGES+1 (3 cycles with the defaults).
- frame_done asserts in the same cycle that the state becomes DONE.
- busy and bit_index are registered and update in the same cycle as state.
- Minimum pin pulse width: SYNC_STAGES+1 clk cycles. Narrower pulses may be missed. This requires no special handling: real consoles use ≥6 µs, about 384 cycles.
- Counter widths: timeout counter $clog2(TIMEOUT_CYCLES+1); the counter saturates and never wraps.

## Structure
- Shared package nes_pad_pkg holds:
  - the state enum (IDLE, LOAD, SHIFT, DONE);
  - NES bit-order constants (A=0, B=1, SELECT=2, START=3, UP=4, DOWN=5, LEFT=6, RIGHT=7);
  - SNES bit-order constants (B, Y, SELECT, START, UP, DOWN, LEFT, RIGHT, A, X, L, R, then 4 reserved bits);
  - the default timeout value.
- One sub-module: pad_pin_sync. It implements a SYNC_STAGES-deep synchroniser plus an edge register producing rise/fall pulses, and is instantiated twice (latch, clk).

## Test plan
- NES frame, buttons=16'h0081 (A, RIGHT): 12 µs latch, then 8 clk pulses at 6 µs half-period. pad_data reads 0,1,1,1,1,1,1,0, then holds 0. frame_done pulses once after the 8th rise.
- SNES mode (NUM_BITS=16), buttons=16'h0F01: pad_data reads 0,1,1,1,1,1,1,1, then 0 for bits 8–11, then 1 for bits 12–15. frame_done pulses after the 16th rise.
- Latch held high while buttons toggles bit 0: pad_data follows ~buttons[0] within SYNC_STAGES+1 cycles. Clk pulses during latch leave bit_index = 0.
- Re-latch after the 3rd clk rise: state returns to LOAD, bit_index = 0, the new frame is sent from bit 0, and no frame_done pulse for the abandoned frame.
- Latch fall, then no clk for 64000 cycles: state goes to IDLE, pad_data = 1, busy = 0, and frame_done is never asserted.
- Reset asserted during SHIFT at bit_index = 4: next cycle pad_data = 1, busy = 0, bit_index = 0. A subsequent full frame transfers correctly.
